// File: rtl/countdown_hms.sv
// -----------------------------------------------------------------------------
// countdown_hms
//   Loadable BCD hours:minutes:seconds countdown timer. Each 1 Hz tick while
//   running removes one second, borrowing down the digit chain
//   (s1 -> s10 -> m1 -> m10 -> h1 -> h10). Reaching 00:00:00 moves to the
//   terminal EXPIRED state, where the value stays at zero until the next load.
//
// Parameters
//   HOUR_MAX  largest hour value accepted on load (0..39); larger loads clamp
//
// Ports
//   clk                     system clock, rising edge
//   rst                     asynchronous active-high reset
//   tick                    1 Hz strobe, one decrement per strobe in RUN
//   load                    captures ld_* digits (clamped), goes to IDLE
//   ld_h10..ld_s1           load digits (2,4,3,4,3,4 bits)
//   start                   IDLE/PAUSED -> RUN when value is nonzero
//   pause                   RUN -> PAUSED
//   h10,h1,m10,m1,s10,s1    current BCD digits (registered)
//   running                 high in RUN
//   expired                 high in EXPIRED
//   done                    one-cycle pulse on entry to EXPIRED
// -----------------------------------------------------------------------------
module countdown_hms #(
  parameter int HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [1:0] ld_h10,
  input  logic [3:0] ld_h1,
  input  logic [2:0] ld_m10,
  input  logic [3:0] ld_m1,
  input  logic [2:0] ld_s10,
  input  logic [3:0] ld_s1,
  input  logic       start,
  input  logic       pause,
  output logic [1:0] h10,
  output logic [3:0] h1,
  output logic [2:0] m10,
  output logic [3:0] m1,
  output logic [2:0] s10,
  output logic [3:0] s1,
  output logic       running,
  output logic       expired,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam logic [1:0] HMAX_TENS  = 2'(HOUR_MAX / 10);
  localparam logic [3:0] HMAX_UNITS = 4'(HOUR_MAX % 10);
  localparam logic [5:0] HMAX_VAL   = 6'(HOUR_MAX);

  state_t     r_state, w_state_next;
  logic [1:0] r_h10, w_h10_next;
  logic [3:0] r_h1,  w_h1_next;
  logic [2:0] r_m10, w_m10_next;
  logic [3:0] r_m1,  w_m1_next;
  logic [2:0] r_s10, w_s10_next;
  logic [3:0] r_s1,  w_s1_next;
  logic       r_running, r_expired, r_done;
  logic       w_done_next;

  // ---------------------------------------------------------------------------
  // Load-value clamping: units first, then the combined hour value.
  // ---------------------------------------------------------------------------
  logic [3:0] w_ld_h1_c, w_ld_m1_c, w_ld_s1_c;
  logic [2:0] w_ld_m10_c, w_ld_s10_c;
  logic [1:0] w_ld_h10_c;
  logic [3:0] w_ld_h1_f;
  logic [5:0] w_ld_hours;

  assign w_ld_h1_c  = (ld_h1  > 4'd9) ? 4'd9 : ld_h1;
  assign w_ld_m1_c  = (ld_m1  > 4'd9) ? 4'd9 : ld_m1;
  assign w_ld_s1_c  = (ld_s1  > 4'd9) ? 4'd9 : ld_s1;
  assign w_ld_m10_c = (ld_m10 > 3'd5) ? 3'd5 : ld_m10;
  assign w_ld_s10_c = (ld_s10 > 3'd5) ? 3'd5 : ld_s10;
  assign w_ld_hours = ({4'd0, ld_h10} * 6'd10) + {2'd0, w_ld_h1_c};
  assign w_ld_h10_c = (w_ld_hours > HMAX_VAL) ? HMAX_TENS  : ld_h10;
  assign w_ld_h1_f  = (w_ld_hours > HMAX_VAL) ? HMAX_UNITS : w_ld_h1_c;

  // ---------------------------------------------------------------------------
  // One-second decrement with borrow. A digit borrows only when every digit
  // below it is zero; each borrowing digit reloads with its maximum.
  // ---------------------------------------------------------------------------
  logic       w_b_s10, w_b_m1, w_b_m10, w_b_h1, w_b_h10;
  logic [1:0] w_dec_h10;
  logic [3:0] w_dec_h1, w_dec_m1, w_dec_s1;
  logic [2:0] w_dec_m10, w_dec_s10;

  assign w_b_s10 = (r_s1  == 4'd0);
  assign w_b_m1  = w_b_s10 && (r_s10 == 3'd0);
  assign w_b_m10 = w_b_m1  && (r_m1  == 4'd0);
  assign w_b_h1  = w_b_m10 && (r_m10 == 3'd0);
  assign w_b_h10 = w_b_h1  && (r_h1  == 4'd0);

  assign w_dec_s1  = (r_s1 == 4'd0) ? 4'd9 : r_s1 - 4'd1;
  assign w_dec_s10 = !w_b_s10 ? r_s10 : ((r_s10 == 3'd0) ? 3'd5 : r_s10 - 3'd1);
  assign w_dec_m1  = !w_b_m1  ? r_m1  : ((r_m1  == 4'd0) ? 4'd9 : r_m1  - 4'd1);
  assign w_dec_m10 = !w_b_m10 ? r_m10 : ((r_m10 == 3'd0) ? 3'd5 : r_m10 - 3'd1);
  assign w_dec_h1  = !w_b_h1  ? r_h1  : ((r_h1  == 4'd0) ? 4'd9 : r_h1  - 4'd1);
  // h10 never underflows: a zero value is never decremented.
  assign w_dec_h10 = w_b_h10 ? r_h10 - 2'd1 : r_h10;

  logic w_nonzero, w_is_one;
  assign w_nonzero = |{r_h10, r_h1, r_m10, r_m1, r_s10, r_s1};
  assign w_is_one  = ~|{r_h10, r_h1, r_m10, r_m1, r_s10} && (r_s1 == 4'd1);

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority: load > pause > start > tick. A strobe that is
  // not meaningful in the current state falls through to lower priorities.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_h10_next   = r_h10;
    w_h1_next    = r_h1;
    w_m10_next   = r_m10;
    w_m1_next    = r_m1;
    w_s10_next   = r_s10;
    w_s1_next    = r_s1;
    w_done_next  = 1'b0;

    if (load) begin
      w_state_next = ST_IDLE;
      w_h10_next   = w_ld_h10_c;
      w_h1_next    = w_ld_h1_f;
      w_m10_next   = w_ld_m10_c;
      w_m1_next    = w_ld_m1_c;
      w_s10_next   = w_ld_s10_c;
      w_s1_next    = w_ld_s1_c;
    end else if (pause && (r_state == ST_RUN)) begin
      w_state_next = ST_PAUSED;
    end else if (start && ((r_state == ST_IDLE) || (r_state == ST_PAUSED)) && w_nonzero) begin
      // start wins over a coincident tick: no decrement on this edge
      w_state_next = ST_RUN;
    end else if (tick && (r_state == ST_RUN)) begin
      w_h10_next = w_dec_h10;
      w_h1_next  = w_dec_h1;
      w_m10_next = w_dec_m10;
      w_m1_next  = w_dec_m1;
      w_s10_next = w_dec_s10;
      w_s1_next  = w_dec_s1;
      if (w_is_one) begin
        w_state_next = ST_EXPIRED;
        w_done_next  = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State, digit and flag registers. Flags are decoded from the next state so
  // they line up with the digits on the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_h10     <= 2'd0;
      r_h1      <= 4'd0;
      r_m10     <= 3'd0;
      r_m1      <= 4'd0;
      r_s10     <= 3'd0;
      r_s1      <= 4'd0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_h10     <= w_h10_next;
      r_h1      <= w_h1_next;
      r_m10     <= w_m10_next;
      r_m1      <= w_m1_next;
      r_s10     <= w_s10_next;
      r_s1      <= w_s1_next;
      r_running <= (w_state_next == ST_RUN);
      r_expired <= (w_state_next == ST_EXPIRED);
      r_done    <= w_done_next;
    end
  end

  assign h10     = r_h10;
  assign h1      = r_h1;
  assign m10     = r_m10;
  assign m1      = r_m1;
  assign s10     = r_s10;
  assign s1      = r_s1;
  assign running = r_running;
  assign expired = r_expired;
  assign done    = r_done;

endmodule

// File: tb/tb_countdown_hms.sv
// -----------------------------------------------------------------------------
// tb_countdown_hms
//   Directed bench for countdown_hms. Each step pushes the expected outputs
//   (time as 0xHHMMSS plus running/expired/done) to a queue, drives the
//   strobes for one clock edge, then pops and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_countdown_hms;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [1:0] ld_h10 = '0;
  logic [3:0] ld_h1 = '0;
  logic [2:0] ld_m10 = '0;
  logic [3:0] ld_m1 = '0;
  logic [2:0] ld_s10 = '0;
  logic [3:0] ld_s1 = '0;
  logic [1:0] h10;
  logic [3:0] h1;
  logic [2:0] m10;
  logic [3:0] m1;
  logic [2:0] s10;
  logic [3:0] s1;
  logic       running, expired, done;

  countdown_hms #(.HOUR_MAX(23)) dut (
    .clk(clk), .rst(rst), .tick(tick), .load(load),
    .ld_h10(ld_h10), .ld_h1(ld_h1), .ld_m10(ld_m10),
    .ld_m1(ld_m1), .ld_s10(ld_s10), .ld_s1(ld_s1),
    .start(start), .pause(pause),
    .h10(h10), .h1(h1), .m10(m10), .m1(m1), .s10(s10), .s1(s1),
    .running(running), .expired(expired), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [26:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [26:0] observed();
    return {2'b00, h10, h1, 1'b0, m10, m1, 1'b0, s10, s1, running, expired, done};
  endfunction

  task automatic push(input string tag, input logic [23:0] t, input bit r, input bit e, input bit d);
    exp_t x;
    x.tag = tag;
    x.vec = {t, r, e, d};
    exp_q.push_back(x);
  endtask

  task automatic check();
    exp_t x;
    logic [26:0] obs;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d entries required >0", exp_q.size());
      return;
    end
    x = exp_q.pop_front();
    obs = observed();
    n_cmp++;
    assert (obs === x.vec)
    else begin
      n_fail++;
      $error("FAIL %s: observed t=%h run=%b exp=%b done=%b required t=%h run=%b exp=%b done=%b",
             x.tag, obs[26:3], obs[2], obs[1], obs[0], x.vec[26:3], x.vec[2], x.vec[1], x.vec[0]);
    end
    $display("step %-14s t=%h run=%b exp=%b done=%b", x.tag, obs[26:3], obs[2], obs[1], obs[0]);
  endtask

  // One edge with the given strobes, then compare against the expectation.
  task automatic step(input string tag, input bit l, input bit st, input bit p, input bit t,
                      input logic [23:0] et, input bit er, input bit ee, input bit ed);
    push(tag, et, er, ee, ed);
    load = l; start = st; pause = p; tick = t;
    @(posedge clk);
    #1;
    load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    check();
  endtask

  task automatic set_ld(input logic [1:0] a, input logic [3:0] b, input logic [2:0] c,
                        input logic [3:0] d, input logic [2:0] e, input logic [3:0] f);
    ld_h10 = a; ld_h1 = b; ld_m10 = c; ld_m1 = d; ld_s10 = e; ld_s1 = f;
  endtask

  initial begin
    // reset
    repeat (2) @(posedge clk);
    #1;
    push("reset", 24'h000000, 0, 0, 0);
    check();
    rst = 1'b0;

    // 1: seconds borrow into minutes
    set_ld(0, 0, 0, 1, 0, 5);
    step("t1_load",  1, 0, 0, 0, 24'h000105, 0, 0, 0);
    step("t1_start", 0, 1, 0, 0, 24'h000105, 1, 0, 0);
    step("t1_tick1", 0, 0, 0, 1, 24'h000104, 1, 0, 0);
    step("t1_tick2", 0, 0, 0, 1, 24'h000103, 1, 0, 0);
    step("t1_tick3", 0, 0, 0, 1, 24'h000102, 1, 0, 0);
    step("t1_tick4", 0, 0, 0, 1, 24'h000101, 1, 0, 0);
    step("t1_tick5", 0, 0, 0, 1, 24'h000100, 1, 0, 0);
    step("t1_borrow", 0, 0, 0, 1, 24'h000059, 1, 0, 0);

    // 2: full borrow chain through hours
    set_ld(0, 1, 0, 0, 0, 0);
    step("t2_load",  1, 0, 0, 0, 24'h010000, 0, 0, 0);
    step("t2_start", 0, 1, 0, 0, 24'h010000, 1, 0, 0);
    step("t2_tick",  0, 0, 0, 1, 24'h005959, 1, 0, 0);

    // 3: expiry, done pulse, no wrap, start ignored
    set_ld(0, 0, 0, 0, 0, 2);
    step("t3_load",   1, 0, 0, 0, 24'h000002, 0, 0, 0);
    step("t3_start",  0, 1, 0, 0, 24'h000002, 1, 0, 0);
    step("t3_tick1",  0, 0, 0, 1, 24'h000001, 1, 0, 0);
    step("t3_expire", 0, 0, 0, 1, 24'h000000, 0, 1, 1);
    step("t3_hold1",  0, 0, 0, 1, 24'h000000, 0, 1, 0);
    step("t3_hold2",  0, 0, 0, 1, 24'h000000, 0, 1, 0);
    step("t3_start",  0, 1, 0, 0, 24'h000000, 0, 1, 0);

    // 4: zero start ignored, load clears expired, clamping
    set_ld(0, 0, 0, 0, 0, 0);
    step("t4_load0",   1, 0, 0, 0, 24'h000000, 0, 0, 0);
    step("t4_start0",  0, 1, 0, 0, 24'h000000, 0, 0, 0);
    set_ld(3, 9, 7, 9, 7, 9);
    step("t4_clamp",   1, 0, 0, 0, 24'h235959, 0, 0, 0);
    set_ld(1, 15, 3, 12, 2, 11);
    step("t4_units",   1, 0, 0, 0, 24'h193929, 0, 0, 0);
    set_ld(2, 4, 0, 0, 0, 0);
    step("t4_hr24",    1, 0, 0, 0, 24'h230000, 0, 0, 0);

    // 5: pause (beats a coincident tick), hold, start+tick no decrement
    set_ld(0, 0, 1, 0, 0, 0);
    step("t5_load",    1, 0, 0, 0, 24'h001000, 0, 0, 0);
    step("t5_start",   0, 1, 0, 0, 24'h001000, 1, 0, 0);
    step("t5_pause",   0, 0, 1, 1, 24'h001000, 0, 0, 0);
    step("t5_hold1",   0, 0, 0, 1, 24'h001000, 0, 0, 0);
    step("t5_hold2",   0, 0, 0, 1, 24'h001000, 0, 0, 0);
    step("t5_hold3",   0, 0, 0, 1, 24'h001000, 0, 0, 0);
    step("t5_resume",  0, 1, 0, 1, 24'h001000, 1, 0, 0);
    step("t5_tick",    0, 0, 0, 1, 24'h000959, 1, 0, 0);
    step("t5_tick2",   0, 0, 0, 1, 24'h000958, 1, 0, 0);

    // 6: asynchronous reset mid-run, then load beats start
    push("t6_async_rst", 24'h000000, 0, 0, 0);
    rst = 1'b1;
    #2;
    check();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push("t6_after_rst", 24'h000000, 0, 0, 0);
    check();
    set_ld(0, 0, 0, 0, 3, 0);
    step("t6_ld_start", 1, 1, 0, 0, 24'h000030, 0, 0, 0);
    step("t6_start",    0, 1, 0, 0, 24'h000030, 1, 0, 0);
    step("t6_tick",     0, 0, 0, 1, 24'h000029, 1, 0, 0);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d entries required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Guard against a stalled simulation.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish required finish by 100000");
    $fatal(1, "timeout");
  end

endmodule
